// File: rtl/bus_pkg.sv
// Shared bus timing definitions: the eight instruction-cycle phases and cycle length,
// used by the ROM reader and by the ROM/RAM bus models.
package bus_pkg;

  localparam int CYCLE_LEN = 8;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    return (p == PH_X3) ? PH_A1 : phase_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/bus_phase_gen.sv
// Free-running 8-phase instruction-cycle counter with a registered sync strobe
// that is high exactly while the phase is X3.
module bus_phase_gen
  import bus_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   halt,
  output phase_t phase,
  output logic   sync
);

  // Reset lands in X3 so the first cycle after reset is a sync cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= PH_X3;
      sync  <= 1'b1;
    end else if (!halt) begin
      phase <= next_phase(phase);
      sync  <= (next_phase(phase) == PH_X3);
    end
  end

endmodule

// File: rtl/rom_bus_reader.sv
// ROM byte reader on the shared 4-bit bus. Defining BUS_READER_BURST_EN adds req_len
// and reads req_len+1 consecutive bytes per request.
module rom_bus_reader
  import bus_pkg::*;
#(
  parameter logic [11:0] IDLE_ADDR = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
`ifdef BUS_READER_BURST_EN
  input  logic [3:0]  req_len,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic [3:0]  data_i,
  output logic [3:0]  data_o,
  output logic        data_en,
  output logic        sync,
  output logic        rom_cmd,
  output logic        ram_cmd_n
);

  phase_t      phase;
  phase_t      nxt_phase;
  logic        pending_valid;
  logic [11:0] pending_addr;
`ifdef BUS_READER_BURST_EN
  logic [3:0]  pending_len;
`endif
  logic        active;
  logic [11:0] cur_addr;
  logic [3:0]  hi_nib;
  logic        active_next;
  logic [11:0] addr_next;
  logic [11:0] bus_addr;

  bus_phase_gen u_phase_gen (
    .clock (clock),
    .reset (reset),
    .halt  (halt),
    .phase (phase),
    .sync  (sync)
  );

  assign nxt_phase = next_phase(phase);
  assign req_ready = !pending_valid;
  assign ram_cmd_n = 1'b1;
  assign rsp_valid = active && (phase == PH_X1) && !halt;

  // Promotion happens on the X3->A1 edge; the bus outputs for the coming cycle
  // must already see the promoted request so they can be registered.
  always_comb begin
    active_next = active;
    addr_next   = cur_addr;
    if (phase == PH_X3) begin
      active_next = pending_valid;
      addr_next   = pending_addr;
    end
    bus_addr = active_next ? addr_next : IDLE_ADDR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_addr  <= '0;
`ifdef BUS_READER_BURST_EN
      pending_len   <= '0;
`endif
      active        <= 1'b0;
      cur_addr      <= '0;
      hi_nib        <= '0;
      rsp_data      <= '0;
      data_en       <= 1'b0;
      data_o        <= '0;
      rom_cmd       <= 1'b0;
    end else if (!halt) begin
      active   <= active_next;
      cur_addr <= addr_next;

      // A burst keeps the pending slot occupied, stepping its address, until its last byte is promoted.
      if (phase == PH_X3 && pending_valid) begin
`ifdef BUS_READER_BURST_EN
        if (pending_len == 4'd0) begin
          pending_valid <= 1'b0;
        end else begin
          pending_addr <= pending_addr + 12'd1;
          pending_len  <= pending_len - 4'd1;
        end
`else
        pending_valid <= 1'b0;
`endif
      end else if (req_valid && !pending_valid) begin
        pending_valid <= 1'b1;
        pending_addr  <= req_addr;
`ifdef BUS_READER_BURST_EN
        pending_len   <= req_len;
`endif
      end

      if (phase == PH_M1)
        hi_nib <= data_i;
      if (phase == PH_M2 && active)
        rsp_data <= {hi_nib, data_i};

      data_en <= (nxt_phase == PH_A1) || (nxt_phase == PH_A2) || (nxt_phase == PH_A3);
      rom_cmd <= (nxt_phase == PH_A3) && active_next;
      case (nxt_phase)
        PH_A1:   data_o <= bus_addr[3:0];
        PH_A2:   data_o <= bus_addr[7:4];
        PH_A3:   data_o <= bus_addr[11:8];
        default: data_o <= 4'h0;
      endcase
    end
  end

endmodule

// File: doc/rom_bus_reader.md
ROM_BUS_READER -- requirements
Module: rom_bus_reader

Interface
REQ-001 SHALL have parameter IDLE_ADDR, default 12'h000: address driven in instruction cycles with no active request.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port halt, input, 1: when high, all state holds.
REQ-005 SHALL have port req_valid, input, 1: read request present.
REQ-006 SHALL have port req_addr, input, 12: ROM byte address; [11:8] is the chip id.
REQ-007 SHALL have port req_ready, output, 1: request accepted on an edge where valid and ready are both high.
REQ-008 SHALL have port rsp_valid, output, 1: one-cycle pulse, rsp_data valid; no backpressure.
REQ-009 SHALL have port rsp_data, output, 8: fetched byte, {M1 nibble, M2 nibble}.
REQ-010 SHALL have ports data_i (input, 4), data_o (output, 4) and data_en (output, 1): shared 4-bit bus; data_o is driven when data_en is high.
REQ-011 SHALL have ports sync (output, 1), rom_cmd (output, 1) and ram_cmd_n (output, 1): bus control strobes.

Function
REQ-012 SHALL run free-running 8-cycle instruction cycles, phase 0..7 = A1,A2,A3,M1,M2,X1,X2,X3, with wrap X3->A1.
REQ-013 SHALL assert sync exactly while phase==X3.
REQ-014 SHALL drive data_en=1 during A1/A2/A3 with data_o = addr[3:0], addr[7:4], addr[11:8] respectively; data_en=0 and data_o=0 in all other phases.
REQ-015 SHALL assert rom_cmd during A3 of active cycles only, and SHALL hold ram_cmd_n=1 at all times.
REQ-016 SHALL drive IDLE_ADDR in idle cycles, with rom_cmd=0 and no response.
REQ-017 SHALL hold a one-entry pending register; req_ready = !pending; an accept loads req_addr into pending.
REQ-018 SHALL promote pending on the X3->A1 edge: active=1, cur_addr=pending address, pending cleared; an accept on the same edge is impossible because ready is low.
REQ-019 SHALL sample data_i on the edge ending M1 (high nibble) and on the edge ending M2 (low nibble).
REQ-020 SHALL assert rsp_valid for exactly the X1 cycle of an active instruction cycle; rsp_data holds until the next response.
REQ-021 SHALL give a latency of 5 cycles from the first A1 cycle to rsp_valid; back-to-back requests SHALL produce responses 8 cycles apart.
REQ-022 SHALL freeze phase, pending, active, rsp_data and all outputs while halt=1, except that rsp_valid stays low while halt=1; a frozen X1 SHALL produce exactly one pulse, in the first cycle after halt drops.

Reset
REQ-023 SHALL, on reset, set phase=X3, pending=0, active=0, rsp_data=0, rsp_valid=0, data_en=0, rom_cmd=0, ram_cmd_n=1, and req_ready=1 (sync=1 in the first cycle after reset).
REQ-024 SHALL, when reset is asserted mid-cycle, discard any pending or active request and emit no response for it.
REQ-025 SHALL give reset priority over halt.

Configuration
REQ-026 SHALL, with BUS_READER_BURST_EN defined, add input req_len (4 bits) and read req_len+1 bytes in consecutive instruction cycles; the address increments mod 4096 (0xFFF->0x000), and pending is only released for promotion after the last byte.
REQ-027 SHALL, without BUS_READER_BURST_EN, omit req_len and make every request a single byte.

Structure
REQ-028 SHALL place the phase encodings A1..X3 and the 8-phase cycle length constant in a shared package bus_pkg, reused by the ROM/RAM models.
REQ-029 SHALL implement the phase counter and sync generation in sub-module bus_phase_gen (inputs clock/reset/halt; outputs phase and sync).

Verification
REQ-030 SHALL cover: reset -> phase=X3, sync=1, data_en=0, rom_cmd=0, ram_cmd_n=1, req_ready=1, rsp_valid=0.
REQ-031 SHALL cover: read 0x1A5, ROM model returns M1=0xD and M2=0x4 -> data_o 5, A, 1 in A1-A3, rom_cmd=1 in A3, rsp_data=0xD4 in X1.
REQ-032 SHALL cover: two requests (0x010, 0x011) held valid -> two responses exactly 8 cycles apart, in order, with no idle cycle between them.
REQ-033 SHALL cover: halt high for 3 cycles starting in M1 -> phase frozen, response delayed by exactly 3 cycles, single pulse, data unchanged.
REQ-034 SHALL cover: reset asserted during M2 of an active cycle -> no rsp_valid; the next cycle drives IDLE_ADDR with rom_cmd=0.
REQ-035 SHALL cover, with BUS_READER_BURST_EN: addr 0xFFE, len 2 -> bytes from 0xFFE, 0xFFF, 0x000 in consecutive instruction cycles, req_ready low until the last A1.
